// File: rtl/dm_delay_tap_ctrl_if.sv
// Command, status and IOD delay-line signals for one DDR3 DM lane tap sequencer.
// The training/fabric side and the IOD model use the master view; the sequencer uses the slave view.
interface dm_delay_tap_ctrl_if #(
  parameter int TAP_W = 8
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic             CMD_DIR;
  logic [TAP_W-1:0] CMD_VALUE;
  logic             DONE;
  logic [1:0]       DONE_STATUS;
  logic [TAP_W-1:0] TAP_COUNT;
  logic             ERR_STICKY;
  logic             CLR_ERR;
  logic             DELAY_LINE_MOVE;
  logic             DELAY_LINE_DIRECTION;
  logic             DELAY_LINE_LOAD;
  logic             DELAY_LINE_OUT_OF_RANGE;

  modport master (
    output CMD_VALID, CMD_OP, CMD_DIR, CMD_VALUE, CLR_ERR, DELAY_LINE_OUT_OF_RANGE,
    input  CMD_READY, DONE, DONE_STATUS, TAP_COUNT, ERR_STICKY,
           DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_DIR, CMD_VALUE, CLR_ERR, DELAY_LINE_OUT_OF_RANGE,
    output CMD_READY, DONE, DONE_STATUS, TAP_COUNT, ERR_STICKY,
           DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
  );
endinterface

// File: rtl/dm_delay_tap_ctrl.sv
// Tap sequencer for one DDR3 DM lane IOD delay line.
// Turns load / relative / absolute tap commands into spaced LOAD, MOVE and DIRECTION
// pulses while keeping a shadow tap count that never leaves 0..MAX_TAP.
// Registered outputs are set on the edge that enters a state, so a state's pulse is
// visible during the same clock the FSM occupies that state.
module dm_delay_tap_ctrl #(
  parameter int TAP_W       = 8,
  parameter int MAX_TAP     = 127,
  parameter int DEFAULT_TAP = 1,
  parameter int LOAD_CYCLES = 2,
  parameter int GAP_CYCLES  = 4
) (
  input logic               FAB_CLK,
  input logic               SYNC_RST_N,
  dm_delay_tap_ctrl_if.slave bus
);

  localparam int LCW = $clog2(LOAD_CYCLES + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  localparam logic [TAP_W-1:0] MAX_T     = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] DEF_T     = TAP_W'(DEFAULT_TAP);
  localparam logic [LCW-1:0]   LOAD_LAST = LCW'(LOAD_CYCLES - 1);
  localparam logic [GCW-1:0]   GAP_LAST  = GCW'(GAP_CYCLES - 1);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_REL  = 2'b01;
  localparam logic [1:0] OP_ABS  = 2'b10;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_BOUND = 2'b01;
  localparam logic [1:0] ST_OOR   = 2'b10;
  localparam logic [1:0] ST_ILL   = 2'b11;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_MOVE,
    S_GAP,
    S_FIN
  } state_t;

  state_t           state;
  logic             ready_q;
  logic             done_q;
  logic [1:0]       status_q;
  logic             err_q;
  logic [TAP_W-1:0] tap_q;
  logic             move_q;
  logic             load_q;
  logic             dir_q;
  logic [TAP_W-1:0] steps_q;
  logic [LCW-1:0]   load_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic             move_hit;
  logic             from_init;

  logic             accept;
  logic             abs_up;
  logic [TAP_W-1:0] abs_diff;
  logic             new_dir;
  logic [TAP_W-1:0] new_steps;
  logic             move_dir;
  logic [TAP_W-1:0] move_steps;
  logic             move_blocked;
  logic             enter_load;
  logic             enter_move;
  logic             enter_gap;
  logic             enter_fin;
  logic [1:0]       fin_code;
  logic             fin_silent;

  assign accept     = (state == S_IDLE) && ready_q && bus.CMD_VALID;
  assign abs_up     = bus.CMD_VALUE > tap_q;
  assign abs_diff   = abs_up ? (bus.CMD_VALUE - tap_q) : (tap_q - bus.CMD_VALUE);
  assign fin_silent = from_init && !accept;

  // Decode direction and step count of the command being offered; LOAD and illegal ops keep the old direction
  always_comb begin
    new_dir   = dir_q;
    new_steps = steps_q;
    if (bus.CMD_OP == OP_REL) begin
      new_dir   = bus.CMD_DIR;
      new_steps = bus.CMD_VALUE;
    end else if (bus.CMD_OP == OP_ABS) begin
      new_dir   = abs_up;
      new_steps = abs_diff;
    end
  end

  // Next-state decision; a move entered from IDLE uses the freshly decoded command instead of the latched one
  always_comb begin
    enter_load   = 1'b0;
    enter_move   = 1'b0;
    enter_gap    = 1'b0;
    enter_fin    = 1'b0;
    fin_code     = ST_OK;
    move_dir     = (state == S_IDLE) ? new_dir : dir_q;
    move_steps   = (state == S_IDLE) ? new_steps : steps_q;
    move_blocked = move_dir ? (tap_q == MAX_T) : (tap_q == '0);
    case (state)
      S_INIT: enter_load = 1'b1;
      S_IDLE: begin
        if (accept) begin
          case (bus.CMD_OP)
            OP_LOAD: enter_load = 1'b1;
            OP_REL: begin
              if (bus.CMD_VALUE == '0) enter_fin = 1'b1;
              else enter_move = 1'b1;
            end
            OP_ABS: begin
              if (bus.CMD_VALUE > MAX_T) begin
                enter_fin = 1'b1;
                fin_code  = ST_ILL;
              end else if (abs_diff == '0) begin
                enter_fin = 1'b1;
              end else begin
                enter_move = 1'b1;
              end
            end
            default: begin
              enter_fin = 1'b1;
              fin_code  = ST_ILL;
            end
          endcase
        end
      end
      S_LOAD: enter_gap = (load_cnt == '0);
      S_MOVE: begin
        if (move_hit) begin
          enter_fin = 1'b1;
          fin_code  = ST_BOUND;
        end else begin
          enter_gap = 1'b1;
        end
      end
      S_GAP: begin
        if (bus.DELAY_LINE_OUT_OF_RANGE) begin
          enter_fin = 1'b1;
          fin_code  = ST_OOR;
        end else if (gap_cnt == '0) begin
          if (steps_q == '0) enter_fin = 1'b1;
          else enter_move = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer state, shadow tap count, IOD pulses and completion reporting
  always_ff @(posedge FAB_CLK) begin
    if (!SYNC_RST_N) begin
      state     <= S_INIT;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      err_q     <= 1'b0;
      tap_q     <= DEF_T;
      move_q    <= 1'b0;
      load_q    <= 1'b0;
      dir_q     <= 1'b0;
      steps_q   <= '0;
      load_cnt  <= '0;
      gap_cnt   <= '0;
      move_hit  <= 1'b0;
      from_init <= 1'b1;
    end else begin
      move_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      if (bus.CLR_ERR) err_q <= 1'b0;
      if (accept) begin
        dir_q     <= new_dir;
        steps_q   <= new_steps;
        from_init <= 1'b0;
      end
      if (enter_load) begin
        state    <= S_LOAD;
        load_q   <= 1'b1;
        load_cnt <= LOAD_LAST;
      end else if (enter_move) begin
        state    <= S_MOVE;
        move_hit <= move_blocked;
        if (!move_blocked) begin
          move_q  <= 1'b1;
          tap_q   <= move_dir ? (tap_q + TAP_W'(1)) : (tap_q - TAP_W'(1));
          steps_q <= move_steps - TAP_W'(1);
        end
      end else if (enter_gap) begin
        state   <= S_GAP;
        gap_cnt <= GAP_LAST;
        if (state == S_LOAD) begin
          tap_q   <= DEF_T;
          steps_q <= '0;
        end
      end else if (enter_fin) begin
        state <= S_FIN;
        if (!fin_silent) begin
          done_q   <= 1'b1;
          status_q <= fin_code;
        end
        if (fin_code != ST_OK) err_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: ready_q <= 1'b1;
          S_LOAD: begin
            load_q   <= 1'b1;
            load_cnt <= load_cnt - LCW'(1);
          end
          S_GAP:  gap_cnt <= gap_cnt - GCW'(1);
          S_FIN: begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Direction switches on the accept cycle itself so the IOD sees it a clock ahead of the first step
  assign bus.DELAY_LINE_DIRECTION = accept ? new_dir : dir_q;

  assign bus.CMD_READY       = ready_q;
  assign bus.DONE            = done_q;
  assign bus.DONE_STATUS     = status_q;
  assign bus.TAP_COUNT       = tap_q;
  assign bus.ERR_STICKY      = err_q;
  assign bus.DELAY_LINE_MOVE = move_q;
  assign bus.DELAY_LINE_LOAD = load_q;

endmodule

// File: doc/dm_delay_tap_ctrl.md
Name: dm_delay_tap_ctrl

Overview:
Sequencer for one DDR3 DM lane IOD delay line. It turns fabric tap commands (load default, relative move, absolute set) into correctly spaced DELAY_LINE_LOAD, DELAY_LINE_MOVE and DELAY_LINE_DIRECTION pulses, and keeps a shadow tap count. It enforces the tap range and aborts on DELAY_LINE_OUT_OF_RANGE. It sits in the fabric domain between the write-leveling/training logic and the lane IOD.

Parameters:
TAP_W, 8, width of tap count and command value
MAX_TAP, 127, highest legal tap index
DEFAULT_TAP, 1, tap value after a LOAD (matches the IOD static TX delay)
LOAD_CYCLES, 2, width of the DELAY_LINE_LOAD pulse in clocks (>=1)
GAP_CYCLES, 4, idle clocks after each MOVE/LOAD pulse before the next action (>=1)

Ports:
FAB_CLK  in  1  fabric clock; the only clock
SYNC_RST_N  in  1  synchronous active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  command accepted when CMD_VALID&CMD_READY
CMD_OP  in  2  00 LOAD, 01 REL move, 10 ABS set, 11 illegal
CMD_DIR  in  1  REL only: 1 = increment delay, 0 = decrement
CMD_VALUE  in  TAP_W  REL: step count; ABS: target tap
DONE  out  1  one-cycle completion pulse
DONE_STATUS  out  2  valid with DONE: 00 ok, 01 boundary hit, 10 out-of-range from IOD, 11 illegal command
TAP_COUNT  out  TAP_W  shadow tap count
ERR_STICKY  out  1  set on any non-ok status
CLR_ERR  in  1  clears ERR_STICKY
DELAY_LINE_MOVE  out  1  one-cycle step pulse to IOD
DELAY_LINE_DIRECTION  out  1  step direction to IOD
DELAY_LINE_LOAD  out  1  load pulse to IOD
DELAY_LINE_OUT_OF_RANGE  in  1  IOD range flag

Behaviour:
- All state is updated on the FAB_CLK rising edge. SYNC_RST_N=0 sampled forces the reset values, overriding any operation in progress.
- Reset values: MOVE=0, LOAD=0, DIRECTION=0, CMD_READY=0, DONE=0, DONE_STATUS=00, ERR_STICKY=0, TAP_COUNT=DEFAULT_TAP, state=INIT.
- States: INIT, IDLE, LOAD, MOVE, GAP, FIN.
- INIT: entered after reset. Behaves exactly like LOAD, but FIN does not pulse DONE. This resynchronises the hardware delay line with TAP_COUNT.
- IDLE: CMD_READY=1. On accept, latch the op, direction and step count, then:
  - LOAD op -> LOAD.
  - REL op: steps = CMD_VALUE, dir = CMD_DIR. If steps = 0 -> FIN with status 00.
  - ABS op: if CMD_VALUE > MAX_TAP -> FIN with status 11. Otherwise dir = (CMD_VALUE > TAP_COUNT) and steps = |CMD_VALUE - TAP_COUNT|. If steps = 0 -> FIN with status 00.
  - Op 11 -> FIN with status 11.
- CMD_READY is 0 in every state except IDLE.
- DELAY_LINE_DIRECTION is driven from the latched dir on the accept cycle and held until the next accept. It is therefore stable at least 1 clock before the first MOVE pulse.
- LOAD: DELAY_LINE_LOAD=1 for LOAD_CYCLES clocks. On the last of those clocks TAP_COUNT<=DEFAULT_TAP, then -> GAP with steps = 0.
- MOVE (1 clock), boundary check first:
  - If (dir=1 and TAP_COUNT=MAX_TAP) or (dir=0 and TAP_COUNT=0): no pulse, -> FIN with status 01.
  - Otherwise DELAY_LINE_MOVE=1 for exactly this clock, TAP_COUNT±1, steps-1, -> GAP.
- GAP: count GAP_CYCLES clocks.
  - If DELAY_LINE_OUT_OF_RANGE is sampled 1 in any GAP clock -> FIN with status 10 immediately. TAP_COUNT keeps its already-updated value.
  - At count end: steps = 0 -> FIN, else -> MOVE.
- Minimum MOVE pulse spacing is GAP_CYCLES+1 clocks.
- FIN: DONE=1 with DONE_STATUS for 1 clock (none after INIT). ERR_STICKY<=1 if status != 00. -> IDLE.
- DONE_STATUS holds its last value until the next DONE.
- ERR_STICKY: if CLR_ERR and a new error occur in the same cycle, set wins.
- Latency: a REL command of N steps accepted at cycle 0 gives the first MOVE at cycle 1 and DONE at cycle 1+N·(1+GAP_CYCLES).
- TAP_COUNT never leaves 0..MAX_TAP.
- DELAY_LINE_OUT_OF_RANGE is ignored outside GAP.

Test Plan:
- Reset release, defaults -> LOAD high for clocks 1-2 after reset, CMD_READY=0 until clock 7, TAP_COUNT=1, no DONE pulse.
- REL up 3 from tap 1 -> MOVE pulses at accept+1, +6, +11; DIRECTION=1 throughout; DONE at accept+16 with status 00; TAP_COUNT=4.
- ABS target 0 from tap 4 -> 4 down pulses, TAP_COUNT=0, status 00. Then REL down 2 -> no MOVE pulse, DONE status 01, ERR_STICKY=1.
- ABS target 200 (above MAX_TAP=127) -> no pulses, status 11. Then CLR_ERR -> ERR_STICKY=0.
- REL up 5, with OUT_OF_RANGE forced high during the 2nd GAP -> exactly 2 MOVE pulses, status 10, TAP_COUNT = start+2.
- SYNC_RST_N low during the 3rd GAP of a REL up 6 -> all outputs at reset values next clock, INIT LOAD sequence reruns, TAP_COUNT=1.
